// File: rtl/multiplier_pkg.sv
// Shared types and constants for the sequential 4x4 shift-add multiplier.
package multiplier_pkg;

    localparam int N     = 4;
    localparam int STEPS = 4;
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/multiplier_datapath.sv
// A/Q/M registers with the conditional 5-bit add followed by a right shift of {carry,A,Q}.
module multiplier_datapath
    import multiplier_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic           step,
    input  logic [N-1:0]   mcand,
    input  logic [N-1:0]   mplier,
    output logic [N-1:0]   a,
    output logic [N-1:0]   q,
    output logic [2*N-1:0] next_prod
);

    logic [N-1:0] m;
    logic [N:0]   sum;
    logic [N-1:0] next_a;
    logic [N-1:0] next_q;

    // The carry is bit N of the sum; the shift moves it into A's MSB, so no
    // carry state survives past the edge.
    always_comb begin
        sum       = {1'b0, a};
        if (q[0]) begin
            sum = {1'b0, a} + {1'b0, m};
        end
        next_a    = sum[N:1];
        next_q    = {sum[0], q[N-1:1]};
        next_prod = {next_a, next_q};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m <= '0;
            a <= '0;
            q <= '0;
        end else if (load) begin
            m <= mcand;
            q <= mplier;
            a <= '0;
        end else if (step) begin
            a <= next_a;
            q <= next_q;
        end
    end

endmodule

// File: rtl/multiplier.sv
// Sequential unsigned shift-add multiplier: start loads operands, four steps later busy drops.
module multiplier
    import multiplier_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    output logic [2*N-1:0]   Output,
    output logic             busy,
    input  logic [N-1:0]     Multiplicand,
    input  logic [N-1:0]     Multiplier,
    input  logic             start,
    output logic [CNT_W-1:0] count,
    output logic [N-1:0]     s,
    output logic [N-1:0]     d
);

    // Handshake: start is a level; every edge it is high (re)loads the operands
    // and raises busy. busy falls on the edge that completes the 4th step, on
    // which Output becomes valid and is held until a later run completes.

    state_t         state;
    logic           step;
    logic [2*N-1:0] next_prod;

    assign step = !start && (state == LOAD || state == RUN);

    multiplier_datapath u_datapath (
        .clk       (clk),
        .rst       (rst),
        .load      (start),
        .step      (step),
        .mcand     (Multiplicand),
        .mplier    (Multiplier),
        .a         (s),
        .q         (d),
        .next_prod (next_prod)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            count  <= '0;
            Output <= '0;
        end else if (start) begin
            state <= LOAD;
            busy  <= 1'b1;
            count <= '0;
        end else begin
            case (state)
                LOAD, RUN: begin
                    count <= count + CNT_W'(1);
                    if (count == CNT_W'(STEPS - 1)) begin
                        Output <= next_prod;
                        busy   <= 1'b0;
                        state  <= DONE;
                    end else begin
                        state <= RUN;
                    end
                end
                default: begin
                    state <= state;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multiplier.sv
// Directed and exhaustive checks of the shift-add multiplier against hand/bench-computed products.
module tb_multiplier;

    logic       clk;
    logic       rst;
    logic [7:0] product;
    logic       busy;
    logic [3:0] mcand;
    logic [3:0] mplier;
    logic       start;
    logic [7:0] count;
    logic [3:0] s;
    logic [3:0] d;

    int checks = 0;
    int errors = 0;

    multiplier dut (
        .clk          (clk),
        .rst          (rst),
        .Output       (product),
        .busy         (busy),
        .Multiplicand (mcand),
        .Multiplier   (mplier),
        .start        (start),
        .count        (count),
        .s            (s),
        .d            (d)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Load operands for 'hold' edges, then drop start one time unit after the last edge.
    task automatic drive_start(input logic [3:0] mc, input logic [3:0] mp, input int hold);
        #1;
        mcand  = mc;
        mplier = mp;
        start  = 1'b1;
        repeat (hold) @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Count edges until busy falls (bounded); returns 99 on timeout.
    task automatic wait_done(output int edges);
        edges = 99;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            #1;
            if (!busy) begin
                edges = i;
                break;
            end
        end
    endtask

    task automatic run_check(input string tag, input logic [3:0] mc, input logic [3:0] mp,
                             input int hold, input logic [7:0] exp);
        int edges;
        drive_start(mc, mp, hold);
        wait_done(edges);
        check({tag, " latency"}, edges, 4);
        check({tag, " product"}, product, exp);
        check({tag, " count"},   count, 4);
        check({tag, " s"},       s, exp[7:4]);
        check({tag, " d"},       d, exp[3:0]);
    endtask

    initial begin
        int edges;
        logic [7:0] exp_p;

        rst    = 1'b1;
        start  = 1'b0;
        mcand  = '0;
        mplier = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("reset product", product, 0);
        check("reset busy",    busy, 0);
        check("reset count",   count, 0);
        check("reset s",       s, 0);
        check("reset d",       d, 0);

        @(posedge clk);
        run_check("3x2",   4'd3,  4'd2,  2, 8'd6);
        run_check("15x15", 4'd15, 4'd15, 1, 8'd225);
        run_check("9x0",   4'd9,  4'd0,  1, 8'd0);
        run_check("15x1",  4'd15, 4'd1,  1, 8'd15);

        // Idle hold: outputs stay put with start low.
        repeat (3) @(posedge clk);
        #1;
        check("idle hold product", product, 15);
        check("idle hold busy",    busy, 0);
        check("idle hold count",   count, 4);

        // Restart mid-run: 5x7 aborted after two steps, 3x4 wins.
        drive_start(4'd5, 4'd7, 1);
        repeat (2) @(posedge clk);
        #1;
        check("abort mid count", count, 2);
        start  = 1'b1;
        mcand  = 4'd3;
        mplier = 4'd4;
        @(posedge clk);
        #1;
        check("abort busy",    busy, 1);
        check("abort count",   count, 0);
        check("abort product", product, 15);
        check("abort d",       d, 4);
        start = 1'b0;
        wait_done(edges);
        check("abort latency", edges, 4);
        check("abort final",   product, 12);

        // Asynchronous reset after two steps.
        drive_start(4'd11, 4'd13, 1);
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("midrst product", product, 0);
        check("midrst busy",    busy, 0);
        check("midrst count",   count, 0);
        check("midrst s",       s, 0);
        check("midrst d",       d, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        run_check("after rst 6x7", 4'd6, 4'd7, 1, 8'd42);

        // Exhaustive sweep of all operand pairs.
        for (int mc = 0; mc < 16; mc++) begin
            for (int mp = 0; mp < 16; mp++) begin
                exp_p = 8'(mc * mp);
                drive_start(4'(mc), 4'(mp), 1);
                wait_done(edges);
                check("sweep latency", edges, 4);
                check("sweep product", product, exp_p);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
